// File: rtl/scaler_pkg.sv
// Shared constants, channel state encoding and helpers for the multi-rate clock scaler.
package scaler_pkg;

  localparam int unsigned MIN_DIV     = 2;
  localparam int unsigned DEF_RST_DIV = 50;
  localparam int unsigned DEF_CNT_W   = 16;
  localparam int unsigned DEF_NCH     = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    RUN_PEND = 2'd2
  } ch_state_e;

  // Channel-select width, never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/multi_rate_scaler_if.sv
// Configuration write channel: valid/ready handshake carrying target channel, period and high time.
interface multi_rate_scaler_if
  import scaler_pkg::*;
#(
  parameter int unsigned NCH   = DEF_NCH,
  parameter int unsigned CNT_W = DEF_CNT_W
);

  localparam int unsigned CH_W = ch_w(NCH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_high,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_high,
    output cfg_ready
  );

endinterface

// File: rtl/scaler_channel.sv
// One divided-clock channel: period counter, active/shadow config pair and run/pending FSM.
module scaler_channel
  import scaler_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned RST_DIV = DEF_RST_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_high,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] RST_DIV_V  = CNT_W'(RST_DIV);
  localparam logic [CNT_W-1:0] RST_HIGH_V = CNT_W'(RST_DIV / 2);
  localparam logic [CNT_W-1:0] MIN_DIV_V  = CNT_W'(MIN_DIV);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_a_q, div_a_d, high_a_q, high_a_d;
  logic [CNT_W-1:0] div_s_q, div_s_d, high_s_q, high_s_d;
  logic             pend_q, pend_d;
  logic             clk_out_d, tick_d;
  logic             wrap, apply;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_a_q  <= RST_DIV_V;
      high_a_q <= RST_HIGH_V;
      div_s_q  <= RST_DIV_V;
      high_s_q <= RST_HIGH_V;
      pend_q   <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_a_q  <= div_a_d;
      high_a_q <= high_a_d;
      div_s_q  <= div_s_d;
      high_s_q <= high_s_d;
      pend_q   <= pend_d;
      clk_out  <= clk_out_d;
      tick     <= tick_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_a_d   = div_a_q;
    high_a_d  = high_a_q;
    div_s_d   = div_s_q;
    high_s_d  = high_s_q;
    pend_d    = pend_q;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;

    wrap  = (cnt_q == div_a_q - CNT_W'(1));
    // Shadow pair lands only at a period boundary, or straight away when stopped.
    apply = pend_q && ((state_q == IDLE) || wrap);

    if (apply) begin
      div_a_d  = (div_s_q < MIN_DIV_V) ? MIN_DIV_V : div_s_q;
      high_a_d = high_s_q;
      pend_d   = 1'b0;
    end

    if (wr) begin
      div_s_d  = wr_div;
      high_s_d = wr_high;
      pend_d   = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = pend_d ? RUN_PEND : RUN;
      end
      RUN, RUN_PEND: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = pend_d ? RUN_PEND : RUN;
          cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d != IDLE) begin
      clk_out_d = (cnt_d < high_a_d);
      tick_d    = (cnt_d == '0);
    end
  end

  assign pending = pend_q;

endmodule

// File: rtl/multi_rate_scaler.sv
// Multi-channel clock divider top: reset release synchroniser, config decode and channel array.
module multi_rate_scaler
  import scaler_pkg::*;
#(
  parameter int unsigned NCH     = DEF_NCH,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned RST_DIV = DEF_RST_DIV
) (
  input  logic               clk_50MHz,
  input  logic               rst_n,
  input  logic               enable,
  multi_rate_scaler_if.slave cfg,
  output logic [NCH-1:0]     clk_out,
  output logic [NCH-1:0]     tick
);

  localparam int unsigned CH_W = ch_w(NCH);

  logic [1:0]     rst_sync_q;
  logic           rst_core_n;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] sel_c;
  logic [NCH-1:0] wr_c;
  logic           ready_c;

  // Assert immediately, release two clocks after rst_n rises.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_core_n = rst_sync_q[1];

  // Out-of-range channel numbers select nothing, so ready stays low for them.
  always_comb begin
    sel_c = '0;
    for (int i = 0; i < NCH; i++) begin
      sel_c[i] = (cfg.cfg_ch == CH_W'(i));
    end
  end

  assign ready_c       = |(sel_c & ~pend);
  assign wr_c          = sel_c & ~pend & {NCH{cfg.cfg_valid}};
  assign cfg.cfg_ready = ready_c;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    scaler_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (RST_DIV)
    ) u_ch (
      .clk     (clk_50MHz),
      .rst_n   (rst_core_n),
      .enable  (enable),
      .wr      (wr_c[g]),
      .wr_div  (cfg.cfg_div),
      .wr_high (cfg.cfg_high),
      .pending (pend[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: doc/multi_rate_scaler.md
MULTI_RATE_SCALER -- requirements
Module: multi_rate_scaler

Interface
REQ-001 The block SHALL have parameter NCH, default 2, giving the number of independent output channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of each divide and high-time register.
REQ-003 The block SHALL have parameter RST_DIV, default 50, giving the reset divide ratio (50 MHz to 1 MHz).
REQ-004 The block SHALL have port clk_50MHz  input  1  as its single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n  input  1  as its reset, which is asynchronous and active-low.
REQ-006 The block SHALL have port enable  input  1  as the global run enable.
REQ-007 The block SHALL have port cfg_valid  input  1  to request a configuration write.
REQ-008 The block SHALL have port cfg_ready  output  1  to accept a configuration write.
REQ-009 The block SHALL have port cfg_ch  input  $clog2(NCH) (min 1)  to select the target channel.
REQ-010 The block SHALL have port cfg_div  input  CNT_W  to set the period in clk_50MHz cycles.
REQ-011 The block SHALL have port cfg_high  input  CNT_W  to set the high time in clk_50MHz cycles.
REQ-012 The block SHALL have port clk_out  output  NCH  to carry the divided clocks, one bit per channel.
REQ-013 The block SHALL have port tick  output  NCH  to carry a one-cycle strobe at the start of each channel period.

Function
REQ-014 Each channel SHALL hold an active pair (div_a, high_a), a shadow pair (div_s, high_s), a pending flag and a counter cnt.
REQ-015 While enable=1, cnt SHALL count 0..div_a-1 and wrap to 0.
REQ-016 clk_out[i] SHALL be registered and equal 1 exactly in the cycles where cnt_i < high_a_i.
REQ-017 tick[i] SHALL be registered and equal 1 exactly in the cycles where cnt_i = 0 and enable = 1.
REQ-018 A write SHALL occur when cfg_valid & cfg_ready at a rising edge; it loads the shadow pair of channel cfg_ch and sets pending.
REQ-019 cfg_ready SHALL equal ~pending[cfg_ch] (combinational) and SHALL be 0 when cfg_ch >= NCH.
REQ-020 A pending shadow pair SHALL be copied to the active pair on the edge where cnt wraps (cnt = div_a-1), clearing pending, so that no truncated or glitched period is produced.
REQ-021 A cfg_div value below 2 SHALL be clamped to 2 when loaded into the active pair.
REQ-022 high_a = 0 SHALL give a constant-low clk_out; high_a >= div_a SHALL give a constant-high clk_out; tick SHALL continue in both cases.
REQ-023 Each channel SHALL implement three states: IDLE (enable=0), RUN (pending=0) and RUN_PEND (pending=1).
REQ-024 In IDLE, cnt SHALL hold 0, clk_out and tick SHALL be 0, and any pending pair SHALL be applied on the next edge.
REQ-025 The transition IDLE->RUN SHALL occur on the first edge with enable=1; cnt is then 0 with tick=1 in that cycle.
REQ-026 The transition RUN/RUN_PEND->IDLE SHALL occur on the first edge with enable=0, with an immediate stop and no period completion.
REQ-027 When a write and a wrap occur on the same edge for the same channel, cfg_ready SHALL be 0 (pending already set); a write to a non-pending channel on its wrap edge SHALL be applied at the following wrap.
REQ-028 Channels SHALL be independent; a write to one channel SHALL NOT disturb the phase of the others.

Reset
REQ-029 While rst_n=0, each channel SHALL reset to cnt=0, div_a=div_s=RST_DIV, high_a=high_s=RST_DIV/2, pending=0, clk_out=0, tick=0.
REQ-030 Reset asserted mid-period SHALL take effect immediately, regardless of the clock; release SHALL be synchronised to clk_50MHz by a 2-flop release synchroniser.

Structure
REQ-031 Package scaler_pkg SHALL hold MIN_DIV=2, the default values for RST_DIV, CNT_W and NCH, and the channel state enum {IDLE, RUN, RUN_PEND}.
REQ-032 The per-channel counter, shadow registers and state machine SHALL be one sub-module, scaler_channel, instantiated NCH times; multi_rate_scaler holds the cfg decode only.

Verification
REQ-033 The bench SHALL check that after reset with enable=1, both channels have a period of 50 cycles with clk_out high for 25 cycles and tick every 50 cycles.
REQ-034 The bench SHALL check that a write of ch1 div=4 high=1 at cnt=10 leaves the current 50-cycle period intact and gives periods of 4 (1 high) after the wrap, with cfg_ready for ch1 low until the wrap.
REQ-035 The bench SHALL check that cfg_div=1 gives a period of 2, and that (div=5, high=0) gives a constant low and (div=5, high=10) a constant high, with tick every 5 cycles.
REQ-036 The bench SHALL check that dropping enable at cnt=7 forces outputs to 0 on the next edge, and that re-enabling gives tick=1 with cnt=0 on the first cycle.
REQ-037 The bench SHALL check that rst_n low mid-period with a pending write clears outputs asynchronously, discards the pending write, and restores period 50.
REQ-038 The bench SHALL check that a write to ch0 does not change the tick timing of ch1 across 200 cycles.
